// File: rtl/hw_call_stack_if.sv
// Request/response bundle between the ID/EX stage (master) and the hardware call stack (slave).
interface hw_call_stack_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             clear_flags;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             stack_overflow;
  logic             stack_underflow;

  modport master (
    output push, pop, data_in, clear_flags,
    input  top, count, empty, full, stack_overflow, stack_underflow
  );

  modport slave (
    input  push, pop, data_in, clear_flags,
    output top, count, empty, full, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/hw_call_stack.sv
// Return-address LIFO with a registered top-of-stack copy, occupancy count and
// sticky overflow/underflow flags for the CPU status port.
module hw_call_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  hw_call_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_IDLE, OP_PUSH, OP_PUSH_FULL, OP_POP, OP_POP_LAST, OP_POP_EMPTY, OP_REPLACE
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] top_r;
  logic             empty_r;
  logic             full_r;
  logic             ovf_r;
  logic             udf_r;

  op_e              op_s;
  logic             is_empty_s;
  logic             is_full_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;
  logic [CW-1:0]    count_next_s;
  logic [WIDTH-1:0] top_next_s;
  logic             ovf_next_s;
  logic             udf_next_s;

  assign is_empty_s = (count_r == CW'(0));
  assign is_full_s  = (count_r == CW'(DEPTH));
  assign rd_idx_s   = AW'(count_r - CW'(2));

  // Classify the request against the current occupancy; one case per edge
  always_comb begin
    op_s = OP_IDLE;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full_s) op_s = OP_PUSH_FULL;
        else           op_s = OP_PUSH;
      end
      2'b01: begin
        if (is_empty_s)                  op_s = OP_POP_EMPTY;
        else if (count_r == CW'(1))      op_s = OP_POP_LAST;
        else                             op_s = OP_POP;
      end
      2'b11: begin
        if (is_empty_s) op_s = OP_PUSH;
        else            op_s = OP_REPLACE;
      end
      default: op_s = OP_IDLE;
    endcase
  end

  // Next-state for count/top and write address selection
  always_comb begin
    count_next_s = count_r;
    top_next_s   = top_r;
    wr_idx_s     = AW'(count_r);
    case (op_s)
      OP_PUSH: begin
        count_next_s = count_r + CW'(1);
        top_next_s   = bus.data_in;
      end
      OP_POP: begin
        count_next_s = count_r - CW'(1);
        top_next_s   = mem[rd_idx_s];
      end
      OP_POP_LAST: begin
        count_next_s = CW'(0);
        top_next_s   = {WIDTH{1'b0}};
      end
      OP_REPLACE: begin
        wr_idx_s   = AW'(count_r - CW'(1));
        top_next_s = bus.data_in;
      end
      default: begin
        count_next_s = count_r;
        top_next_s   = top_r;
      end
    endcase
  end

  // A new event on the same edge as clear_flags wins
  assign ovf_next_s = (ovf_r & ~bus.clear_flags) | (op_s == OP_PUSH_FULL);
  assign udf_next_s = (udf_r & ~bus.clear_flags) | (op_s == OP_POP_EMPTY);

  // Storage array: not reset, writes suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && ((op_s == OP_PUSH) || (op_s == OP_REPLACE))) begin
      mem[wr_idx_s] <= bus.data_in;
    end
  end

  // Registered status and top-of-stack outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= CW'(0);
      top_r   <= {WIDTH{1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      top_r   <= top_next_s;
      empty_r <= (count_next_s == CW'(0));
      full_r  <= (count_next_s == CW'(DEPTH));
      ovf_r   <= ovf_next_s;
      udf_r   <= udf_next_s;
    end
  end

  assign bus.top             = top_r;
  assign bus.count           = count_r;
  assign bus.empty           = empty_r;
  assign bus.full            = full_r;
  assign bus.stack_overflow  = ovf_r;
  assign bus.stack_underflow = udf_r;
endmodule

// File: tb/tb_hw_call_stack.sv
// Directed-vector and reference-queue bench for the hardware call stack.
module tb_hw_call_stack;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       clr;
    logic [7:0] e_top;
    logic [3:0] e_count;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [19];
  logic [7:0] mq [$];
  logic m_ovf;
  logic m_udf;

  hw_call_stack_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  hw_call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] t, input logic [3:0] c,
                              input logic o, input logic u);
    chk({tag, " top"},   32'(bus.top),   32'(t));
    chk({tag, " count"}, 32'(bus.count), 32'(c));
    chk({tag, " empty"}, 32'(bus.empty), 32'(c == 4'd0));
    chk({tag, " full"},  32'(bus.full),  32'(c == 4'(DEPTH)));
    chk({tag, " ovf"},   32'(bus.stack_overflow),  32'(o));
    chk({tag, " udf"},   32'(bus.stack_underflow), 32'(u));
  endtask

  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
    @(negedge clk);
    bus.push        = p;
    bus.pop         = q;
    bus.data_in     = d;
    bus.clear_flags = c;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic p, input logic q, input logic [7:0] d, input logic c);
    logic ovf_ev;
    logic udf_ev;
    ovf_ev = 1'b0;
    udf_ev = 1'b0;
    if (p && q) begin
      if (mq.size() == 0) mq.push_back(d);
      else mq[mq.size() - 1] = d;
    end else if (p) begin
      if (mq.size() == DEPTH) ovf_ev = 1'b1;
      else mq.push_back(d);
    end else if (q) begin
      if (mq.size() == 0) udf_ev = 1'b1;
      else void'(mq.pop_back());
    end
    m_ovf = (m_ovf && !c) || ovf_ev;
    m_udf = (m_udf && !c) || udf_ev;
  endtask

  initial begin
    logic       rp, rq, rc;
    logic [7:0] rd;
    logic [7:0] etop;

    bus.push        = 1'b1;
    bus.pop         = 1'b0;
    bus.data_in     = 8'hAA;
    bus.clear_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 8'h00, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 8'(8'h10 + i), 4'(i + 1), 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h55, 1'b0, 8'h17, 4'd8, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++)
      vecs[9 + i] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'(8'h16 - i), 4'(7 - i), 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0};

    @(negedge clk);
    bus.push = 1'b0;
    rst      = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
      expect_state($sformatf("vec%0d", i), vecs[i].e_top, vecs[i].e_count,
                   vecs[i].e_ovf, vecs[i].e_udf);
    end

    // Simultaneous push+pop replaces the top; on empty it acts as a push
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    expect_state("repl", 8'h99, 4'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    expect_state("repl_pop", 8'h01, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    expect_state("repl_drain", 8'h00, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    expect_state("pp_empty", 8'h33, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Flag clear race against a fresh overflow
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b0);
    expect_state("ovf", 8'h27, 4'd8, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    expect_state("clr", 8'h27, 4'd8, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h88, 1'b1);
    expect_state("clr_race", 8'h27, 4'd8, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b0);
    expect_state("repl_full", 8'h44, 4'd8, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with a push still requested
    bus.push = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    expect_state("midrst", 8'h00, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.push        = 1'b0;
    bus.pop         = 1'b0;
    bus.clear_flags = 1'b0;
    rst             = 1'b1;

    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      rp = ($urandom_range(0, 99) < 50);
      rq = ($urandom_range(0, 99) < 40);
      rc = ($urandom_range(0, 15) == 0);
      rd = 8'($urandom_range(0, 255));
      step(rp, rq, rd, rc);
      model_step(rp, rq, rd, rc);
      etop = (mq.size() == 0) ? 8'h00 : mq[mq.size() - 1];
      expect_state($sformatf("rnd%0d", n), etop, 4'(mq.size()), m_ovf, m_udf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hw_call_stack.md
Name: hw_call_stack

Overview:
- Hardware return-address/data stack inside MIPSCPU, fed by the ID/EX stage on call/return instructions.
- Supplies the current top-of-stack to the PC-select logic.
- Produces the sticky stack_overflow flag that MIPSCPU drives on its top-level port, alongside zero and carry.
- Fully synchronous storage with registered outputs; no external memory.

Parameters:
- DEPTH, 8, number of stack entries; must be ≥2.
- WIDTH, 8, width of each entry in bits (PC width of the core).
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  push data_in this cycle.
- pop  input  1  pop the top entry this cycle.
- data_in  input  WIDTH  value to push (return address).
- clear_flags  input  1  clears the sticky overflow/underflow flags.
- top  output  WIDTH  registered copy of the current top entry; 0 when empty.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- stack_overflow  output  1  sticky: a push was attempted while full.
- stack_underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst low, asynchronous, no clock needed): count=0, top=0, empty=1, full=0, stack_overflow=0, stack_underflow=0. Storage array is not reset. Release is synchronous to the next rising edge.
- Internal pointer sp equals count; entry i is held in mem[i]; top mirrors mem[sp-1].
- All outputs are registered, one cycle of latency: after the edge that performs an operation, the outputs reflect the new state.
- Operations are evaluated in priority order; exactly one case applies per edge:
  - Idle (push=0, pop=0): state holds.
  - Push only, not full: mem[sp]<=data_in; sp+1; top<=data_in.
  - Push only, full: no write; sp unchanged; top unchanged; stack_overflow<=1.
  - Pop only, count≥2: sp-1; top<=mem[sp-2].
  - Pop only, count==1: sp<=0; top<=0.
  - Pop only, empty: no change; stack_underflow<=1.
  - Push and pop together, not empty: replace top. mem[sp-1]<=data_in, sp unchanged, top<=data_in, no flags set. This also applies when full.
  - Push and pop together, empty: behaves as push only; no underflow flag.
- empty and full are derived from the next count and registered with it.
- Sticky flags hold until reset or clear_flags.
  - clear_flags clears both flags at the edge.
  - If a new overflow or underflow event occurs on the same edge as clear_flags, set wins for that flag.
- count never wraps: it saturates at DEPTH and at 0 by construction of the rules above.
- Mid-operation reset: any in-flight push or pop is discarded; state returns to reset values immediately.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=0 for 2 cycles with push=1, data_in=8'hAA. Expect count=0, top=0, empty=1, full=0, both flags 0. Assert rst mid-cycle and confirm outputs clear before the next edge.
- Fill and overflow (DEPTH=8): push 8'h10..8'h17 on consecutive cycles. Expect count=8, full=1, top=8'h17. Push 8'h55 once more: count stays 8, top stays 8'h17, stack_overflow=1.
- Drain and underflow: from full, pop 8 times. Expect top sequence 8'h16,15,14,13,12,11,10, then 0; empty=1. A 9th pop sets stack_underflow=1 and count stays 0.
- Simultaneous push+pop: with stack holding 8'h01,8'h02, assert push+pop with 8'h99. Expect count=2, top=8'h99. Then pop gives top=8'h01. On an empty stack, push+pop with 8'h33 gives count=1, top=8'h33, underflow stays 0.
- Flag clear race: with overflow=1 and full, assert clear_flags alone: overflow goes to 0. Next, assert clear_flags together with push: overflow=1 (set wins).
- Random push/pop for 1000 cycles against a reference queue model. Check top, count, empty, full and both flags every cycle.
